imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with optional PC-relative target, behind a
// 2-entry skid buffer (output register + skid register) with valid/ready handshakes.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int ADD_PC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_code,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Imm_out,
  output logic [XLEN-1:0] target_out,
  output logic [2:0]      fmt_out,
  output logic            illegal_out,
  output logic [1:0]      state_dbg
);

  // Handshake: a beat moves on a side only in a cycle where valid && ready are
  // both high at the rising edge; once out_valid is raised the bundle holds
  // stable until out_ready is seen, and valid never waits on ready.

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
  } bundle_t;

  state_t  state, state_n;
  bundle_t dec, out_q, skid_q;
  logic    accept, drain, load_out, load_skid, skid_to_out;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  logic [2:0]      fmt;
  logic            illegal;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (inst_code[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        imm32 = {{20{inst_code[31]}}, inst_code[31:20]};
        fmt   = FMT_I;
      end
      7'b0100011: begin
        imm32 = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
        fmt   = FMT_S;
      end
      7'b1100011: begin
        imm32 = {{19{inst_code[31]}}, inst_code[31], inst_code[7],
                 inst_code[30:25], inst_code[11:8], 1'b0};
        fmt   = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        imm32 = {inst_code[31:12], 12'b0};
        fmt   = FMT_U;
      end
      7'b1101111: begin
        imm32 = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                 inst_code[20], inst_code[30:21], 1'b0};
        fmt   = FMT_J;
      end
      // Legal encodings that simply carry no immediate.
      7'b0110011, 7'b0111011, 7'b0001111, 7'b1110011: fmt = FMT_NONE;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm_x       = {XLEN{imm32[31]}};
    imm_x[31:0] = imm32;
    dec.imm     = imm_x;
    dec.fmt     = fmt;
    dec.illegal = illegal;
    dec.target  = '0;
    if ((ADD_PC != 0) && !illegal) dec.target = pc_in + imm_x;
  end

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_n     = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      S_EMPTY: if (accept) begin
        state_n  = S_ONE;
        load_out = 1'b1;
      end
      S_ONE: begin
        if (accept && !drain) begin
          state_n   = S_FULL;
          load_skid = 1'b1;
        end else if (!accept && drain) begin
          state_n = S_EMPTY;
        end else if (accept && drain) begin
          load_out = 1'b1;
        end
      end
      S_FULL: if (drain) begin
        state_n     = S_ONE;
        skid_to_out = 1'b1;
      end
      default: state_n = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_EMPTY;
      in_ready <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_n;
      // Registered ready: low exactly while the skid register holds data.
      in_ready <= (state_n != S_FULL);
      if (load_out)         out_q <= dec;
      else if (skid_to_out) out_q <= skid_q;
      if (load_skid)        skid_q <= dec;
    end
  end

  assign out_valid   = (state != S_EMPTY);
  assign Imm_out     = out_q.imm;
  assign target_out  = out_q.target;
  assign fmt_out     = out_q.fmt;
  assign illegal_out = out_q.illegal;
  assign state_dbg   = state;

endmodule
